// File: rtl/led_pwm_engine.sv
// led_pwm_engine: multi-channel LED PWM (off/static/blink/breathe) with debounced active-low buttons
module led_pwm_engine #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_LOG2    = 6,
  parameter int BREATHE_LOG2  = 2,
  parameter int BUTTONS       = 2,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_strobe,
  input  logic [BUTTONS-1:0]  btn_raw,
  output logic [BUTTONS-1:0]  btn_pressed,
  output logic [BUTTONS-1:0]  btn_press
);
  localparam int BLW = BLINK_LOG2 > 0 ? BLINK_LOG2 : 1;
  localparam int BRW = BREATHE_LOG2 > 0 ? BREATHE_LOG2 : 1;
  typedef enum logic [1:0] {M_OFF, M_STATIC, M_BLINK, M_BREATHE} mode_t;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLW-1:0] blink_cnt;
  logic [BRW-1:0] breathe_cnt;
  logic blink_phase, boundary, tick;
  assign boundary = &pwm_cnt;
  assign tick = boundary && (BREATHE_LOG2 == 0 || &breathe_cnt);
  always_ff @(posedge clk)
    if (!rst_n) begin
      pwm_cnt       <= '0;
      blink_cnt     <= '0;
      breathe_cnt   <= '0;
      blink_phase   <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      pwm_cnt       <= pwm_cnt + 1'b1;
      period_strobe <= boundary;
      if (boundary) begin
        blink_cnt   <= blink_cnt + 1'b1;
        breathe_cnt <= breathe_cnt + 1'b1;
        if (BLINK_LOG2 == 0 || &blink_cnt) blink_phase <= ~blink_phase;
      end
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mode_t pend_mode, mode;
    logic [PWM_BITS-1:0] pend_duty, duty, level, eff;
    logic down, out_q;
    always_comb eff = mode == M_OFF ? '0 : mode == M_STATIC ? duty :
                      mode == M_BLINK ? (blink_phase ? duty : '0) : level;
    // pending regs are applied only at the boundary; the breathe step uses the duty being applied
    always_ff @(posedge clk)
      if (!rst_n) begin
        pend_mode <= M_OFF;
        pend_duty <= '0;
        mode      <= M_OFF;
        duty      <= '0;
        level     <= '0;
        down      <= 1'b0;
        out_q     <= 1'b0;
      end else begin
        if (cfg_we && cfg_chan == 3'(c)) begin
          pend_mode <= mode_t'(cfg_mode);
          pend_duty <= cfg_duty;
        end
        if (boundary) begin
          mode <= pend_mode;
          duty <= pend_duty;
          if (pend_mode != mode) begin
            level <= '0;
            down  <= 1'b0;
          end else if (tick && mode == M_BREATHE) begin
            if (!down) begin
              if (level >= pend_duty) begin
                level <= pend_duty;
                down  <= 1'b1;
              end else level <= level + 1'b1;
            end else if (level == '0) down <= 1'b0;
            else level <= level - 1'b1;
          end
        end
        out_q <= pwm_cnt < eff;
      end
    assign pwm_out[c] = out_q;
  end
  for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
    logic [1:0] sync;
    logic [DEBOUNCE_BITS-1:0] cnt;
    logic stable, pressed_q, press_q;
    always_ff @(posedge clk)
      if (!rst_n) begin
        sync      <= 2'b11;
        cnt       <= '0;
        stable    <= 1'b1;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
      end else begin
        sync      <= {sync[0], btn_raw[b]};
        cnt       <= (sync[1] == stable || &cnt) ? '0 : cnt + 1'b1;
        if (sync[1] != stable && &cnt) stable <= sync[1];
        pressed_q <= ~stable;
        press_q   <= ~stable & ~pressed_q;
      end
    assign btn_pressed[b] = pressed_q;
    assign btn_press[b]   = press_q;
  end
endmodule
